// File: rtl/adder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : adder_seq (with helper adder_nbit)
//  Description : Multi-cycle adder. A request (a, b, cin) accepted in IDLE is
//                added SLICE bits per cycle through a single (SLICE+1)-bit
//                slice adder, least-significant slice first, with the carry
//                held in a register between cycles. The result is held in
//                DONE until the consumer takes it.
//  Ports       : clk        rising-edge clock
//                rst_n      asynchronous active-low reset
//                in_valid   request valid            in_ready  accept possible
//                a, b       WIDTH-bit operands       cin       carry-in
//                sub        (ADDER_SEQ_SUB_EN only) 1 = compute a - b
//                out_valid  result valid             out_ready consumer ready
//                sum        WIDTH-bit result         cout      carry-out
//  Options     : ADDER_SEQ_SUB_EN -- define to add the sub port and the
//                operand-B inversion used for subtraction.
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// adder_nbit: combinational WIDTH-bit adder, carry-out discarded (callers
// widen the operands by one bit and read the carry from the result MSB).
// IMPL_TYPE 0 = behavioural add, otherwise explicit ripple-carry chain.
// ----------------------------------------------------------------------------
module adder_nbit #(
    parameter int WIDTH     = 9,
    parameter int IMPL_TYPE = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum
);

    generate
        if (IMPL_TYPE == 0) begin : g_behav
            assign sum = a + b + {{(WIDTH-1){1'b0}}, cin};
        end else begin : g_ripple
            logic [WIDTH-1:0] w_c;
            assign w_c[0] = cin;
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                assign sum[i] = a[i] ^ b[i] ^ w_c[i];
                if (i < WIDTH - 1) begin : g_carry
                    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
                end
            end
        end
    endgenerate

endmodule

// ----------------------------------------------------------------------------
// adder_seq
// ----------------------------------------------------------------------------
module adder_seq #(
    parameter int WIDTH     = 32,
    parameter int SLICE     = 8,
    parameter int IMPL_TYPE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDER_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int c_N     = WIDTH / SLICE;
    // Keep the index at least one bit wide so N == 1 still elaborates.
    localparam int c_IDX_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(c_N - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_carry;
    logic [c_IDX_W-1:0] r_idx;

    logic [SLICE-1:0]   w_a_slice;
    logic [SLICE-1:0]   w_b_slice;
    logic [SLICE:0]     w_slice_sum;

    // Operand B and carry-in as loaded on accept; subtraction is a + ~b + 1.
    logic [WIDTH-1:0]   w_b_load;
    logic               w_carry_load;

`ifdef ADDER_SEQ_SUB_EN
    assign w_b_load     = sub ? ~b : b;
    assign w_carry_load = sub ? 1'b1 : cin;
`else
    assign w_b_load     = b;
    assign w_carry_load = cin;
`endif

    // Select the operand slice addressed by the current index.
    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int s = 0; s < c_N; s++) begin
            if (r_idx == c_IDX_W'(s)) begin
                w_a_slice = r_a[s*SLICE +: SLICE];
                w_b_slice = r_b[s*SLICE +: SLICE];
            end
        end
    end

    // One extra bit on each operand so sum[SLICE] is the slice carry-out.
    adder_nbit #(
        .WIDTH     (SLICE + 1),
        .IMPL_TYPE (IMPL_TYPE)
    ) u_slice_add (
        .a   ({1'b0, w_a_slice}),
        .b   ({1'b0, w_b_slice}),
        .cin (r_carry),
        .sum (w_slice_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= w_b_load;
                        r_carry    <= w_carry_load;
                        r_idx      <= '0;
                        r_state    <= RUN;
                        r_in_ready <= 1'b0;
                    end
                end
                RUN: begin
                    for (int s = 0; s < c_N; s++) begin
                        if (r_idx == c_IDX_W'(s)) begin
                            r_sum[s*SLICE +: SLICE] <= w_slice_sum[SLICE-1:0];
                        end
                    end
                    r_carry <= w_slice_sum[SLICE];
                    if (r_idx == c_IDX_LAST) begin
                        r_idx       <= '0;
                        r_cout      <= w_slice_sum[SLICE];
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + c_IDX_ONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule
`default_nettype wire

// File: doc/adder_seq.md
ADDER_SEQ -- requirements
Module: adder_seq

Interface
REQ-001: Parameter WIDTH, default 32, operand/result width in bits.
REQ-002: Parameter SLICE, default 8, bits added per cycle; WIDTH SHALL be an integer multiple of SLICE, N = WIDTH/SLICE.
REQ-003: Parameter IMPL_TYPE, default 0, passed unchanged to the slice adder instance.
REQ-004: clk  input  1  sole clock, all state updates on rising edge.
REQ-005: rst_n  input  1  asynchronous, active-low reset.
REQ-006: in_valid  input  1  request holds valid a/b/cin.
REQ-007: in_ready  output  1  block can accept a request.
REQ-008: a  input  WIDTH  operand A.
REQ-009: b  input  WIDTH  operand B.
REQ-010: cin  input  1  carry-in of the full-width add.
REQ-011: out_valid  output  1  sum/cout hold a completed result.
REQ-012: out_ready  input  1  consumer accepts the result.
REQ-013: sum  output  WIDTH  result bits.
REQ-014: cout  output  1  carry-out of bit WIDTH-1.

Function
REQ-015: Block SHALL instantiate exactly one adder_nbit of width SLICE+1 (operand MSBs tied 0, Cin = carry register), using Sum[SLICE] as slice carry-out.
REQ-016: FSM states SHALL be IDLE, RUN, DONE; in_ready = (state==IDLE), out_valid = (state==DONE).
REQ-017: IDLE: on edge with in_valid&&in_ready, capture a, b into operand registers, carry register <= cin, slice index <= 0, go RUN.
REQ-018: RUN: each cycle add slice [index*SLICE +: SLICE] of captured A and B with carry register; at edge write result into that sum slice, carry register <= slice carry-out, index++.
REQ-019: RUN -> DONE on the edge that writes slice N-1; cout <= carry-out of that slice.
REQ-020: Latency: accept at edge k -> out_valid visible after edge k+N (WIDTH=32, SLICE=8: after edge k+4).
REQ-021: DONE: sum/cout SHALL stay stable while out_valid && !out_ready; on edge with out_ready go IDLE.
REQ-022: in_valid, a, b, cin changes outside the IDLE accept edge SHALL be ignored.
REQ-023: No request accepted in RUN or DONE; peak throughput one add per N+2 cycles.
REQ-024: SLICE == WIDTH SHALL work with N=1 (single RUN cycle).
REQ-025: Arithmetic SHALL be modulo 2^WIDTH with cout = bit WIDTH of A+B+cin.

Reset
REQ-026: rst_n low SHALL immediately force state IDLE, in_ready=1 (once released), out_valid=0, sum=0, cout=0, carry register=0, index=0.
REQ-027: Reset asserted during RUN or DONE SHALL abort the operation with no result delivered.

Configuration
REQ-028: Macro ADDER_SEQ_SUB_EN defined: input port sub (1 bit) added; on accept with sub=1, B register <= ~b and carry register <= 1 (cin ignored), giving A-B with cout=1 meaning no borrow; sub=0 behaves as add.
REQ-029: Macro ADDER_SEQ_SUB_EN undefined: no sub port, add only, logic for inversion absent.

Verification
REQ-030: WIDTH=32,SLICE=8: a=0x0000_00FF, b=0x0000_0001, cin=0 -> sum=0x0000_0100, cout=0, out_valid after 4 edges post-accept.
REQ-031: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0x0000_0000, cout=1 (carry ripples through all 4 slices).
REQ-032: out_ready held 0 for 5 cycles in DONE, a/b toggled meanwhile -> sum/cout unchanged, in_ready=0, then accept on out_ready=1 and return to IDLE.
REQ-033: rst_n pulsed low in 2nd RUN cycle -> out_valid=0, sum=0, cout=0 immediately; next request 0x1+0x2 -> sum=0x3.
REQ-034: SLICE=32: a=0x8000_0000, b=0x8000_0000, cin=0 -> sum=0, cout=1 after 1 edge.
REQ-035: ADDER_SEQ_SUB_EN, sub=1: a=5, b=7 -> sum=0xFFFF_FFFE, cout=0; a=7, b=5 -> sum=2, cout=1.
